// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives one req/ack data-bus transaction per access,
// stalls the pipeline until it completes, and returns extended load data for MEM/WB.
module mem_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemEn_MEM,
    input  logic        MemRW_MEM,
    input  logic [2:0]  WordSizeSel_MEM,
    input  logic [31:0] ALU_o_MEM,
    input  logic [31:0] RS2_MEM,
    output logic [31:0] DMEM_MEM,
    output logic        Stall_MEM,
    output logic        MisAlign_MEM,
    output logic        BusErr_MEM,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [1:0]  fsm_state
);

    // Bus handshake: dbus_req stays high from the start edge until the edge that sees
    // dbus_ack (or the timeout); we/addr/wdata/be are frozen for that whole window and
    // dbus_ack is a single-cycle pulse sampled only while in BUSY.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] dmem_q;
    logic        buserr_q;

    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic        start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane_word;
    logic [31:0] load_ext;

    assign is_half  = (WordSizeSel_MEM[1:0] == 2'b01);
    assign is_word  = WordSizeSel_MEM[1];
    assign misalign = MemEn_MEM & ((is_half & ALU_o_MEM[0]) | (is_word & (ALU_o_MEM[1:0] != 2'b00)));
    assign start    = (state == IDLE) & MemEn_MEM & ~misalign;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = RS2_MEM;
        if (is_word) begin
            be_next    = 4'b1111;
            wdata_next = RS2_MEM;
        end else if (is_half) begin
            be_next    = 4'b0011 << ALU_o_MEM[1:0];
            wdata_next = {2{RS2_MEM[15:0]}};
        end else begin
            be_next    = 4'b0001 << ALU_o_MEM[1:0];
            wdata_next = {4{RS2_MEM[7:0]}};
        end
    end

    // Lane selection uses the address captured at start, not the live EX/MEM value.
    always_comb begin
        lane_word = dbus_rdata >> {lane_q, 3'b000};
        load_ext  = lane_word;
        case (size_q[1:0])
            2'b00:   load_ext = {{24{~size_q[2] & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_ext = {{16{~size_q[2] & lane_word[15]}}, lane_word[15:0]};
            default: load_ext = lane_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            size_q     <= 3'd0;
            lane_q     <= 2'd0;
            dmem_q     <= 32'd0;
            buserr_q   <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_wdata <= 32'd0;
            dbus_be    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        wait_cnt   <= 8'd0;
                        size_q     <= WordSizeSel_MEM;
                        lane_q     <= ALU_o_MEM[1:0];
                        dmem_q     <= 32'd0;
                        buserr_q   <= 1'b0;
                        dbus_req   <= 1'b1;
                        dbus_we    <= MemRW_MEM;
                        dbus_addr  <= {ALU_o_MEM[31:2], 2'b00};
                        dbus_wdata <= wdata_next;
                        dbus_be    <= be_next;
                    end
                end
                BUSY: begin
                    // An ack landing on the final count still wins over the timeout.
                    if (dbus_ack) begin
                        state    <= DONE;
                        dbus_req <= 1'b0;
                        dmem_q   <= dbus_we ? 32'd0 : load_ext;
                        buserr_q <= 1'b0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state    <= DONE;
                        dbus_req <= 1'b0;
                        dmem_q   <= 32'd0;
                        buserr_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    dmem_q   <= 32'd0;
                    buserr_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    dbus_req <= 1'b0;
                end
            endcase
        end
    end

    // Reset masks the combinational outputs so they fall without waiting for a clock.
    assign Stall_MEM    = ~rst & (start | (state == BUSY));
    assign MisAlign_MEM = ~rst & misalign;
    assign DMEM_MEM     = dmem_q;
    assign BusErr_MEM   = buserr_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a spec-level model predicts every output per cycle
// and a single negedge compare process checks the DUT against it.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        MemEn_MEM;
    logic        MemRW_MEM;
    logic [2:0]  WordSizeSel_MEM;
    logic [31:0] ALU_o_MEM;
    logic [31:0] RS2_MEM;
    logic [31:0] DMEM_MEM;
    logic        Stall_MEM;
    logic        MisAlign_MEM;
    logic        BusErr_MEM;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [1:0]  fsm_state;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .MemEn_MEM       (MemEn_MEM),
        .MemRW_MEM       (MemRW_MEM),
        .WordSizeSel_MEM (WordSizeSel_MEM),
        .ALU_o_MEM       (ALU_o_MEM),
        .RS2_MEM         (RS2_MEM),
        .DMEM_MEM        (DMEM_MEM),
        .Stall_MEM       (Stall_MEM),
        .MisAlign_MEM    (MisAlign_MEM),
        .BusErr_MEM      (BusErr_MEM),
        .dbus_req        (dbus_req),
        .dbus_we         (dbus_we),
        .dbus_addr       (dbus_addr),
        .dbus_wdata      (dbus_wdata),
        .dbus_be         (dbus_be),
        .dbus_ack        (dbus_ack),
        .dbus_rdata      (dbus_rdata),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_mis, exp_done, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [32:0] exp_q[$];
    logic [32:0] exp_front;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] sel);
        return 1 << sel[1:0];
    endfunction

    function automatic logic model_mis(input logic [2:0] sel, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sel)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] sel, input logic [31:0] a);
        logic [3:0] be;
        int lo;
        int n;
        lo = int'(a[1:0]);
        n  = nbytes(sel);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] sel, input logic [31:0] rs2);
        logic [31:0] w;
        int n;
        n = nbytes(sel);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] sel, input logic [1:0] lane,
                                              input logic [31:0] rdata);
        logic [31:0] shifted, mask, v;
        int n;
        n = nbytes(sel);
        shifted = rdata >> (8 * int'(lane));
        if (n >= 4) return shifted;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = shifted & mask;
        if (!sel[2] && shifted[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, Stall_MEM}, {31'b0, exp_stall});
            check("req", {31'b0, dbus_req}, {31'b0, exp_req});
            check("misalign", {31'b0, MisAlign_MEM}, {31'b0, exp_mis});
            if (dbus_req) req_cycles++;
            if (exp_req) begin
                check("we", {31'b0, dbus_we}, {31'b0, exp_we});
                check("addr", dbus_addr, exp_addr);
                check("wdata", dbus_wdata, exp_wdata);
                check("be", {28'b0, dbus_be}, {28'b0, exp_be});
            end
            if (exp_done) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 32'd1, 32'd0);
                end else begin
                    exp_front = exp_q.pop_front();
                    check("dmem", DMEM_MEM, exp_front[31:0]);
                    check("buserr", {31'b0, BusErr_MEM}, {31'b0, exp_front[32]});
                end
            end else begin
                check("dmem_idle", DMEM_MEM, 32'd0);
                check("buserr_idle", {31'b0, BusErr_MEM}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input logic stray_ack);
        MemEn_MEM  = 1'b0;
        dbus_ack   = stray_ack;
        dbus_rdata = 32'h5A5A_5A5A;
        exp_stall  = 1'b0;
        exp_req    = 1'b0;
        exp_mis    = 1'b0;
        exp_done   = 1'b0;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
    endtask

    // ack_at < 0 withholds the ack; otherwise it arrives on the ack_at-th BUSY cycle.
    task automatic access(input logic rw, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] rs2, input int ack_at, input logic [31:0] rdata);
        logic mis;
        logic ok;
        int nbusy;
        mis = model_mis(sel, a);
        MemEn_MEM       = 1'b1;
        MemRW_MEM       = rw;
        WordSizeSel_MEM = sel;
        ALU_o_MEM       = a;
        RS2_MEM         = rs2;
        dbus_ack        = 1'b0;
        exp_stall = ~mis;
        exp_req   = 1'b0;
        exp_mis   = mis;
        exp_done  = 1'b0;
        @(posedge clk); #1;
        if (mis) return;
        ok    = (ack_at >= 0) && (ack_at < TMO);
        nbusy = ok ? ack_at + 1 : TMO;
        exp_q.push_back({~ok, (ok && !rw) ? model_ext(sel, a[1:0], rdata) : 32'h0});
        exp_mis   = 1'b0;
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        exp_we    = rw;
        exp_addr  = {a[31:2], 2'b00};
        exp_wdata = model_wdata(sel, rs2);
        exp_be    = model_be(sel, a);
        for (int k = 0; k < nbusy; k++) begin
            dbus_ack   = ok && (k == ack_at);
            dbus_rdata = dbus_ack ? rdata : $urandom;
            @(posedge clk); #1;
        end
        dbus_ack  = 1'b0;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_done  = 1'b1;
        @(posedge clk); #1;
        exp_done  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        MemEn_MEM = 1'b0; MemRW_MEM = 1'b0; WordSizeSel_MEM = 3'd0;
        ALU_o_MEM = 32'd0; RS2_MEM = 32'd0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_done = 1'b0; exp_we = 1'b0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, dbus_req}, 32'd0);
        check("rst_stall", {31'b0, Stall_MEM}, 32'd0);
        check("rst_dmem", DMEM_MEM, 32'd0);
        check("rst_buserr", {31'b0, BusErr_MEM}, 32'd0);
        check("rst_be", {28'b0, dbus_be}, 32'd0);
        check("rst_state", {30'b0, fsm_state}, 32'd0);
        rst = 1'b0;

        // Literal pins on the model itself.
        check("pin_lb", model_ext(3'b000, 2'd3, 32'h80FF_0000), 32'hFFFF_FF80);
        check("pin_lbu", model_ext(3'b100, 2'd3, 32'h80FF_0000), 32'h0000_0080);
        check("pin_lh", model_ext(3'b001, 2'd2, 32'h8001_7FFF), 32'hFFFF_8001);
        check("pin_be_sh", {28'b0, model_be(3'b001, 32'h202)}, 32'h0000_000C);
        check("pin_be_lb", {28'b0, model_be(3'b000, 32'h103)}, 32'h0000_0008);
        check("pin_wdata_sh", model_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
        check("pin_mis_lw", {31'b0, model_mis(3'b010, 32'h101)}, 32'd1);

        chk_en = 1'b1;
        idle(1'b0);

        req_cycles = 0;
        access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
        check("lw_req_cycles", req_cycles, 32'd1);

        // Back-to-back LB then LBU at the same byte.
        access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 32'h80FF_0000);
        access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 32'h80FF_0000);
        access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 2, 32'hFFFF_FFFF);
        idle(1'b0);

        req_cycles = 0;
        access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'h1111_1111);
        idle(1'b0);
        check("mis_no_req", req_cycles, 32'd0);

        access(1'b0, 3'b001, 32'h0000_0102, 32'd0, 0, 32'h8001_7FFF);
        access(1'b0, 3'b101, 32'h0000_0100, 32'd0, 1, 32'h8001_7FFF);
        access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_AA55, 0, 32'd0);
        access(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_BABE, 1, 32'd0);
        access(1'b0, 3'b010, 32'h0000_0304, 32'd0, TMO - 1, 32'h0BAD_F00D);
        idle(1'b0);

        // Timeout with a stray ack afterwards.
        req_cycles = 0;
        access(1'b0, 3'b010, 32'h0000_0008, 32'd0, -1, 32'd0);
        check("timeout_req_cycles", req_cycles, TMO);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset after two wait cycles in BUSY.
        chk_en = 1'b0;
        MemEn_MEM = 1'b1; MemRW_MEM = 1'b0; WordSizeSel_MEM = 3'b010; ALU_o_MEM = 32'h400;
        @(posedge clk); #1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pre_rst_req", {31'b0, dbus_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'b0, dbus_req}, 32'd0);
        check("async_rst_stall", {31'b0, Stall_MEM}, 32'd0);
        check("async_rst_state", {30'b0, fsm_state}, 32'd0);
        MemEn_MEM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(1'b0);
        access(1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 1, 32'd0);
        idle(1'b0);
        idle(1'b0);

        chk_en = 1'b0;
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the EX/MEM and MEM/WB pipeline registers. It takes the effective address, store data and access size from EX/MEM, runs a req/ack transaction on the data-memory bus, and stalls the pipeline until the transaction completes. It returns aligned, sign- or zero-extended load data as `DMEM_MEM` for capture into MEM/WB. It also flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 64: number of `BUSY` cycles without `dbus_ack` before the access is abandoned. Legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `MemEn_MEM` in 1: instruction in MEM is a load or store.
- `MemRW_MEM` in 1: 1 = store, 0 = load.
- `WordSizeSel_MEM` in 3: funct3 encoding.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `ALU_o_MEM` in 32: effective byte address.
- `RS2_MEM` in 32: store data, right-justified.
- `DMEM_MEM` out 32: extended load data; valid in the `DONE` cycle.
- `Stall_MEM` out 1: hold PC and all pipeline registers upstream of MEM/WB.
- `MisAlign_MEM` out 1: combinational misalignment flag.
- `BusErr_MEM` out 1: timeout flag; valid in the `DONE` cycle.
- `dbus_req` out 1: request, registered.
- `dbus_we` out 1: write enable.
- `dbus_addr` out 32: word address, `{ALU_o_MEM[31:2],2'b00}`.
- `dbus_wdata` out 32: store data replicated into the addressed byte lanes.
- `dbus_be` out 4: byte enables.
- `dbus_ack` in 1: one-cycle completion pulse.
- `dbus_rdata` in 32: read word; valid when `dbus_ack` = 1.

## Operation
- Reset value of every output is 0; FSM state is `IDLE`.
- FSM states and transitions:
  - `IDLE` -> `BUSY`: when `MemEn_MEM` = 1 and `MisAlign_MEM` = 0. The request, address, size, direction, wdata and be are registered on that edge.
  - `BUSY` -> `DONE`: on `dbus_ack` = 1, or when the timeout counter reaches `TIMEOUT`-1.
  - `DONE` -> `IDLE`: unconditionally.
- Misalignment rule: `MisAlign_MEM` = `MemEn_MEM` & ((size half & addr[0]) | (size word & addr[1:0] != 0)).
  - A misaligned access issues no bus transaction and causes no stall.
  - `DMEM_MEM` = 0 for that cycle.
- `Stall_MEM` = (`IDLE` & `MemEn_MEM` & !`MisAlign_MEM`) | `BUSY`. It is low in `DONE`, so the pipeline advances exactly once per access.
- `dbus_req` is 1 for the entire time the FSM is in `BUSY` and drops in the cycle after ack. `dbus_we`, `dbus_addr`, `dbus_wdata` and `dbus_be` stay stable while `dbus_req` = 1.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
  - Loads drive the same mask.
- Store data lanes:
  - byte: `{4{RS2[7:0]}}`
  - half: `{2{RS2[15:0]}}`
  - word: `RS2`
- Load extraction: select the lane using the registered `addr[1:0]`. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- The extended read data is registered on the ack edge and held on `DMEM_MEM` through `DONE`. Stores return `DMEM_MEM` = 0.
- Timeout:
  - The 8-bit counter clears on entering `BUSY` and increments each `BUSY` cycle.
  - On timeout, `dbus_req` deasserts, `BusErr_MEM` = 1 in `DONE`, and `DMEM_MEM` = 0.
  - A late ack arriving while in `IDLE` is ignored.
- An ack in the same cycle as timeout counts as success (ack wins).

## Timing
- Minimum access: 3 cycles.
  - C0: `IDLE`, stall = 1.
  - C1: `BUSY`, req = 1, ack = 1.
  - C2: `DONE`, stall = 0, data valid.
  - MEM/WB captures at the end of C2.
- Each wait cycle on `dbus_ack` adds one stall cycle.
- Back-to-back accesses: the second instruction arrives in C3 (`IDLE`) and starts a new transaction. There is no idle bus cycle beyond the `DONE` cycle.
- Asserting `rst` mid-transaction forces `IDLE` immediately: `dbus_req` and `Stall_MEM` go 0 asynchronously, and no completion is reported.
- `MisAlign_MEM` and the `IDLE`-state `Stall_MEM` are combinational from the EX/MEM inputs. All bus outputs are registered.

## Test plan
- LW at 0x100, ack one cycle after req, rdata 0xDEADBEEF:
  - `dbus_addr` = 0x100, be = 1111.
  - `Stall_MEM` high for 2 cycles.
  - `DMEM_MEM` = 0xDEADBEEF in `DONE`.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF_0000:
  - Both use be = 1000.
  - LB gives `DMEM_MEM` = 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x202, RS2 = 0x1234ABCD:
  - `dbus_we` = 1, addr = 0x200, be = 1100, wdata = 0xABCDABCD.
  - `DMEM_MEM` = 0.
- LW at 0x101:
  - `MisAlign_MEM` = 1, `dbus_req` never rises, `Stall_MEM` = 0.
- LW with ack withheld, `TIMEOUT` = 4:
  - req high for exactly 4 cycles.
  - `BusErr_MEM` = 1 and `DMEM_MEM` = 0 in `DONE`.
  - A later stray ack is ignored.
- Assert `rst` during `BUSY` after 2 wait cycles:
  - `dbus_req` and `Stall_MEM` go to 0 without waiting for a clock edge.
  - After release, a following SW completes normally.
